fpu_itof_pipe: RTL

Pipelined, parametrised integer-to-floating-point converter producing a fully packed, rounded IEEE-754-style result. It generalises the combinational itof pre-normaliser: selectable signed/unsigned source, configurable integer and float widths, four rounding modes, exception flags, and a valid/ready streaming interface. It sits beside the FPU datapath as a standalone conversion unit, fed by the operand dispatch and drained by the result writeback arbiter.

---
 rtl/fpu_itof_pipe_if.sv | 31 +++
 rtl/fpu_itof_pipe.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fpu_itof_pipe_if.sv
// Streaming bus for the integer-to-float converter.
// Carries the operand side (Valid_SI/Ready_SO, operand, signedness, rounding mode)
// and the result side (Valid_SO/Ready_SI, packed result, inexact and zero flags).
// master: the environment that feeds operands and drains results.
// slave:  the converter.
interface fpu_itof_pipe_if #(
  parameter int unsigned C_INT_W = 32,
  parameter int unsigned C_EXP   = 8,
  parameter int unsigned C_MANT  = 23
);
  logic                      Valid_SI;
  logic                      Ready_SO;
  logic [C_INT_W-1:0]        Operand_a_DI;
  logic                      Signed_SI;
  logic [1:0]                RM_SI;
  logic                      Valid_SO;
  logic                      Ready_SI;
  logic [C_EXP+C_MANT:0]     Result_DO;
  logic                      Inexact_SO;
  logic                      Zero_SO;

  modport master (
    output Valid_SI, Operand_a_DI, Signed_SI, RM_SI, Ready_SI,
    input  Ready_SO, Valid_SO, Result_DO, Inexact_SO, Zero_SO
  );

  modport slave (
    input  Valid_SI, Operand_a_DI, Signed_SI, RM_SI, Ready_SI,
    output Ready_SO, Valid_SO, Result_DO, Inexact_SO, Zero_SO
  );
endinterface

// File: rtl/fpu_itof_pipe.sv
// Three-stage pipelined integer-to-float converter with IEEE-style rounding.
// Ports:
//   Clk_CI  - clock, rising edge
//   Rst_RBI - asynchronous active-low reset
//   io      - fpu_itof_pipe_if.slave: operand in (valid/ready), packed result out
//             (valid/ready) with inexact and zero flags.
// Stages: S1 captures sign and magnitude, S2 normalises, S3 rounds and packs.
// A single global enable stalls every stage while the output is held.
module fpu_itof_pipe #(
  parameter int unsigned C_INT_W = 32,
  parameter int unsigned C_EXP   = 8,
  parameter int unsigned C_MANT  = 23,
  parameter int unsigned C_BIAS  = 127
) (
  input logic           Clk_CI,
  input logic           Rst_RBI,
  fpu_itof_pipe_if.slave io
);

  localparam int unsigned LzW    = $clog2(C_INT_W + 1);
  localparam int unsigned FracW  = C_INT_W - 1;
  localparam int unsigned PadW   = FracW + C_MANT + 2;
  localparam int unsigned ResW   = 1 + C_EXP + C_MANT;
  localparam int unsigned ExpTop = C_BIAS + C_INT_W - 1;

  logic en;

  logic               v1_q, v2_q, v3_q;
  logic               sign1_q, sign2_q;
  logic [1:0]         rm1_q, rm2_q;
  logic [C_INT_W-1:0] mag1_q;
  logic [FracW-1:0]   frac2_q;
  logic [C_EXP-1:0]   exp2_q;
  logic               zero2_q;
  logic [ResW-1:0]    res3_q;
  logic               inx3_q, zero3_q;

  logic               sign1_d;
  logic [C_INT_W-1:0] mag1_d;
  logic [LzW-1:0]     lz;
  logic [C_INT_W-1:0] norm2_d;
  logic [C_EXP-1:0]   exp2_d;
  logic [PadW-1:0]    pad;
  logic [C_MANT-1:0]  mant, mant_rnd;
  logic               g, s, up, carry;
  logic [C_EXP-1:0]   exp_rnd;
  logic [ResW-1:0]    res3_d;
  logic               inx3_d;

  // Stall only when a result is held and not taken.
  assign en          = ~v3_q | io.Ready_SI;
  assign io.Ready_SO = en;

  // S1: sign and magnitude. The most negative input wraps to 2^(W-1), read as unsigned.
  always_comb begin
    sign1_d = io.Signed_SI & io.Operand_a_DI[C_INT_W-1];
    mag1_d  = sign1_d ? (~io.Operand_a_DI + C_INT_W'(1)) : io.Operand_a_DI;
  end

  // S2: leading-zero count; the highest set bit wins because it is visited last.
  always_comb begin
    lz = LzW'(C_INT_W);
    for (int unsigned i = 0; i < C_INT_W; i++) begin
      if (mag1_q[i]) lz = LzW'(C_INT_W - 1 - i);
    end
    norm2_d = mag1_q << lz;
    exp2_d  = C_EXP'(ExpTop - 32'(lz));
  end

  // S3: round and pack. The fraction is zero-padded so narrow integers still
  // yield a full mantissa plus guard bit.
  always_comb begin
    pad  = {frac2_q, {(C_MANT + 2){1'b0}}};
    mant = pad[PadW-1 -: C_MANT];
    g    = pad[PadW-1-C_MANT];
    s    = |pad[PadW-2-C_MANT:0];
    up   = 1'b0;
    unique case (rm2_q)
      2'b00:   up = g & (s | mant[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = sign2_q & (g | s);
      default: up = ~sign2_q & (g | s);
    endcase
    // A carry out of the mantissa leaves it all-zero; only the exponent moves.
    {carry, mant_rnd} = {1'b0, mant} + (C_MANT + 1)'(up);
    exp_rnd = exp2_q + C_EXP'(carry);
    res3_d  = zero2_q ? '0 : {sign2_q, exp_rnd, mant_rnd};
    inx3_d  = ~zero2_q & (g | s);
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (en) begin
      v1_q <= io.Valid_SI;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // Payload is never reset; it is only observed through the valid bits.
  always_ff @(posedge Clk_CI) begin
    if (en) begin
      sign1_q <= sign1_d;
      mag1_q  <= mag1_d;
      rm1_q   <= io.RM_SI;
      sign2_q <= sign1_q;
      frac2_q <= norm2_d[FracW-1:0];
      exp2_q  <= exp2_d;
      zero2_q <= ~norm2_d[C_INT_W-1];
      rm2_q   <= rm1_q;
      res3_q  <= res3_d;
      inx3_q  <= inx3_d;
      zero3_q <= zero2_q;
    end
  end

  assign io.Valid_SO   = v3_q;
  assign io.Result_DO  = v3_q ? res3_q : '0;
  assign io.Inexact_SO = v3_q & inx3_q;
  assign io.Zero_SO    = v3_q & zero3_q;

endmodule
